stage_mem_hs: RTL



---
 rtl/stage_mem_hs.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/stage_mem_hs.sv
// MEM pipeline stage: decodes LWD/SWD and runs a registered request/acknowledge data-memory handshake.
// Latency: accept cycle + 1..TIMEOUT wait cycles, then a single RESP cycle with done_valid.
// Backpressure: mem_stall holds upstream from accept until the RESP cycle; a missing ack aborts after TIMEOUT waits.
module stage_mem_hs #(
  parameter int       WORD_SIZE  = 16,
  parameter int       ADDR_WIDTH = 16,
  parameter bit [3:0] OPCODE_LWD = 4'd7,
  parameter bit [3:0] OPCODE_SWD = 4'd8,
  parameter int       TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  valid_in,
  input  logic [WORD_SIZE-1:0]  instruction,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WORD_SIZE-1:0]  write_data,
  output logic [WORD_SIZE-1:0]  read_data,
  output logic                  done_valid,
  output logic                  mem_stall,
  output logic                  mem_err,
  output logic                  d_readM,
  output logic                  d_writeM,
  output logic [ADDR_WIDTH-1:0] d_address,
  inout  wire  [WORD_SIZE-1:0]  d_data,
  input  logic                  d_ready
);

  localparam int CW = $clog2(TIMEOUT + 1);
  // Last wait-cycle count value; a miss here means TIMEOUT waits have elapsed.
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, RESP} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0]  wdata_q, wdata_d;
  logic [WORD_SIZE-1:0]  rdata_q, rdata_d;

  logic [3:0] opcode;
  logic       is_ld, is_st;
  logic       unused_instr;

  assign opcode       = instruction[15:12];
  assign unused_instr = ^instruction;
  assign is_ld        = valid_in && (opcode == OPCODE_LWD);
  assign is_st        = valid_in && (opcode == OPCODE_SWD);

  // State and request registers; reset drops any in-flight request silently.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state: issue on accept, finish on ack or timeout, one RESP cycle, back to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (is_ld) begin
          addr_d  = addr;
          rd_d    = 1'b1;
          state_d = RD_WAIT;
        end else if (is_st) begin
          addr_d  = addr;
          wdata_d = write_data;
          wr_d    = 1'b1;
          state_d = WR_WAIT;
        end
      end
      RD_WAIT: begin
        // Counter tops out at TIMEOUT, so it cannot wrap.
        cnt_d = cnt_q + CW'(1);
        if (d_ready) begin
          rdata_d = d_data;
          rd_d    = 1'b0;
          state_d = RESP;
        end else if (cnt_q == TO_LAST) begin
          rdata_d = '0;
          rd_d    = 1'b0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      WR_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (d_ready) begin
          wr_d    = 1'b0;
          state_d = RESP;
        end else if (cnt_q == TO_LAST) begin
          wr_d    = 1'b0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        // Inputs still show the completed instruction here; never re-issue.
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_stall  = ((state_q == IDLE) && (is_ld || is_st)) ||
                      (state_q == RD_WAIT) || (state_q == WR_WAIT);
  assign done_valid = (state_q == RESP);
  assign read_data  = rdata_q;
  assign mem_err    = err_q;
  assign d_readM    = rd_q;
  assign d_writeM   = wr_q;
  assign d_address  = addr_q;
  assign d_data     = ((state_q == WR_WAIT) && wr_q) ? wdata_q : {WORD_SIZE{1'bz}};

endmodule
